phased_array_driver: RTL and testbench

Parametrised N-channel phased-array transducer driver. It generates one PWM carrier per channel from a shared period counter, with per-channel phase delay and a global duty. Shadow registers are written over a simple register-write port and committed atomically at a period boundary. It supports continuous and counted-burst modes. It sits between the serial register front end and the speaker driver ICs, replacing the fixed 37-channel / 4-bit shifter bank.

---
 rtl/phased_array_pkg.sv | 19 +
 rtl/phased_array_driver_if.sv | 12 +
 rtl/pa_channel.sv | 41 ++++
 rtl/phased_array_driver.sv | 173 +++++++++++++++++
 tb/tb_phased_array_driver.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/phased_array_pkg.sv
// rtl/phased_array_pkg.sv - register map, bus widths and FSM encoding for the phased-array driver
package phased_array_pkg;

  localparam int ADDR_W = 7;
  localparam int DATA_W = 8;

  localparam logic [ADDR_W-1:0] REG_ENABLE     = 7'h01;
  localparam logic [ADDR_W-1:0] REG_DUTY       = 7'h02;
  localparam logic [ADDR_W-1:0] REG_CTRL       = 7'h03;
  localparam logic [ADDR_W-1:0] REG_BURST      = 7'h04;
  localparam logic [ADDR_W-1:0] REG_PHASE_BASE = 7'h10;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RUN_CONT  = 2'd1,
    RUN_BURST = 2'd2
  } pa_state_e;

endpackage

// File: rtl/phased_array_driver_if.sv
// rtl/phased_array_driver_if.sv - register write port shared by the front end and the driver
interface phased_array_driver_if;
  import phased_array_pkg::*;

  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  modport master (output wr_en, output wr_addr, output wr_data);
  modport slave  (input  wr_en, input  wr_addr, input  wr_data);

endinterface

// File: rtl/pa_channel.sv
// rtl/pa_channel.sv - one output channel: shadow/active phase pair, carrier compare, output flop
module pa_channel #(
  parameter int PHASE_BITS = 4
) (
  input  logic                  clk,
  input  logic                  res_n,
  input  logic                  i_we,
  input  logic [PHASE_BITS-1:0] i_phase,
  input  logic                  i_copy,
  input  logic [PHASE_BITS-1:0] i_cnt,
  input  logic [PHASE_BITS-1:0] i_duty,
  input  logic                  i_gate,
  output logic                  o_out
);

  logic [PHASE_BITS-1:0] r_phase_s;
  logic [PHASE_BITS-1:0] r_phase_a;
  logic [PHASE_BITS-1:0] w_diff;
  logic                  r_out;

  // Modular subtraction shifts this channel's carrier window by its phase
  assign w_diff = i_cnt - r_phase_a;
  assign o_out  = r_out;

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      r_phase_s <= '0;
      r_phase_a <= '0;
      r_out     <= 1'b0;
    end else begin
      if (i_we) begin
        r_phase_s <= i_phase;
      end
      if (i_copy) begin
        r_phase_a <= r_phase_s;
      end
      r_out <= i_gate && (w_diff < i_duty);
    end
  end

endmodule

// File: rtl/phased_array_driver.sv
// rtl/phased_array_driver.sv - N-channel PWM transducer driver with shadowed registers and burst mode
module phased_array_driver
  import phased_array_pkg::*;
#(
  parameter int N_CH       = 37,
  parameter int PHASE_BITS = 4,
  parameter int BURST_BITS = 8
) (
  input  logic                 clk,
  input  logic                 res_n,
  phased_array_driver_if.slave wr,
  output logic [N_CH-1:0]      out,
  output logic                 active,
  output logic                 commit_pending,
  output logic                 period_tick
);

  localparam logic [PHASE_BITS-1:0] CNT_MAX = '1;

  pa_state_e             r_state;
  pa_state_e             w_state_next;
  logic [PHASE_BITS-1:0] r_cnt;
  logic [PHASE_BITS-1:0] w_cnt_next;
  logic [BURST_BITS-1:0] r_bcnt;
  logic [BURST_BITS-1:0] w_bcnt_next;
  logic [PHASE_BITS-1:0] r_duty_s;
  logic [PHASE_BITS-1:0] r_duty_a;
  logic [BURST_BITS-1:0] r_blen_s;
  logic [BURST_BITS-1:0] w_blen_load;
  logic                  r_en_s;
  logic                  r_mode_s;
  logic                  r_pending;
  logic                  w_we_en;
  logic                  w_we_duty;
  logic                  w_we_ctrl;
  logic                  w_we_burst;
  logic                  w_commit_wr;
  logic                  w_en_next;
  logic                  w_run;
  logic                  w_tick;
  logic                  w_copy;
  logic                  w_en_clr;
  logic                  w_gate;
  logic [PHASE_BITS-1:0] w_duty_in;

  assign w_we_en     = wr.wr_en && (wr.wr_addr == REG_ENABLE);
  assign w_we_duty   = wr.wr_en && (wr.wr_addr == REG_DUTY);
  assign w_we_ctrl   = wr.wr_en && (wr.wr_addr == REG_CTRL);
  assign w_we_burst  = wr.wr_en && (wr.wr_addr == REG_BURST);
  assign w_commit_wr = w_we_ctrl && wr.wr_data[0];

  // Enable is looked at as it is being written so start-up and disable skip the shadow latency
  assign w_en_next   = w_we_en ? wr.wr_data[0] : r_en_s;
  assign w_run       = (r_state != IDLE);
  assign w_tick      = w_run && (r_cnt == CNT_MAX);
  assign w_gate      = w_run && w_en_next;
  assign w_duty_in   = (wr.wr_data > DATA_W'(CNT_MAX)) ? CNT_MAX : wr.wr_data[PHASE_BITS-1:0];
  assign w_blen_load = (r_blen_s == '0) ? BURST_BITS'(1) : r_blen_s;

  assign active         = w_run;
  assign commit_pending = r_pending;
  assign period_tick    = w_tick;

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_bcnt_next  = r_bcnt;
    w_copy       = 1'b0;
    w_en_clr     = 1'b0;
    case (r_state)
      IDLE: begin
        w_cnt_next = '0;
        if (w_en_next) begin
          w_copy       = 1'b1;
          w_state_next = r_mode_s ? RUN_BURST : RUN_CONT;
          w_bcnt_next  = w_blen_load;
        end
      end
      RUN_CONT: begin
        w_cnt_next = r_cnt + PHASE_BITS'(1);
        if (w_tick && r_pending) begin
          w_copy = 1'b1;
          if (r_mode_s) begin
            w_state_next = RUN_BURST;
            w_bcnt_next  = w_blen_load;
          end
        end
      end
      RUN_BURST: begin
        w_cnt_next = r_cnt + PHASE_BITS'(1);
        if (w_tick) begin
          w_copy      = r_pending;
          w_bcnt_next = r_bcnt - BURST_BITS'(1);
          if ((r_bcnt == BURST_BITS'(1)) || (r_bcnt == '0)) begin
            w_state_next = IDLE;
            w_en_clr     = 1'b1;
          end
        end
      end
      default: w_state_next = IDLE;
    endcase
    // A disable write overrides everything and leaves any pending commit untouched
    if (w_run && !w_en_next) begin
      w_state_next = IDLE;
      w_cnt_next   = '0;
      w_copy       = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      r_cnt     <= '0;
      r_bcnt    <= '0;
      r_pending <= 1'b0;
      r_en_s    <= 1'b0;
      r_mode_s  <= 1'b0;
      r_duty_s  <= '0;
      r_blen_s  <= '0;
      r_duty_a  <= '0;
    end else begin
      r_cnt  <= w_cnt_next;
      r_bcnt <= w_bcnt_next;
      if (w_commit_wr) begin
        r_pending <= 1'b1;
      end else if (w_copy) begin
        r_pending <= 1'b0;
      end
      if (w_en_clr) begin
        r_en_s <= 1'b0;
      end else if (w_we_en) begin
        r_en_s <= wr.wr_data[0];
      end
      if (w_we_ctrl) begin
        r_mode_s <= wr.wr_data[1];
      end
      if (w_we_duty) begin
        r_duty_s <= w_duty_in;
      end
      if (w_we_burst) begin
        r_blen_s <= wr.wr_data[BURST_BITS-1:0];
      end
      if (w_copy) begin
        r_duty_a <= r_duty_s;
      end
    end
  end

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    logic w_we_phase;
    assign w_we_phase = wr.wr_en && (wr.wr_addr == (REG_PHASE_BASE + ADDR_W'(gi)));

    pa_channel #(.PHASE_BITS(PHASE_BITS)) u_ch (
      .clk     (clk),
      .res_n   (res_n),
      .i_we    (w_we_phase),
      .i_phase (wr.wr_data[PHASE_BITS-1:0]),
      .i_copy  (w_copy),
      .i_cnt   (r_cnt),
      .i_duty  (r_duty_a),
      .i_gate  (w_gate),
      .o_out   (out[gi])
    );
  end

endmodule

// File: tb/tb_phased_array_driver.sv
// tb/tb_phased_array_driver.sv - directed self-checking bench for phased_array_driver
module tb_phased_array_driver;
  import phased_array_pkg::*;

  localparam int N_CH = 37;
  localparam int PB   = 4;
  localparam int BB   = 8;

  logic            clk = 1'b0;
  logic            res_n = 1'b0;
  logic [N_CH-1:0] out;
  logic            active;
  logic            commit_pending;
  logic            period_tick;

  int n_checks = 0;
  int n_errors = 0;
  int ph = 0;

  phased_array_driver_if wr_bus ();

  phased_array_driver #(.N_CH(N_CH), .PHASE_BITS(PB), .BURST_BITS(BB)) dut (
    .clk            (clk),
    .res_n          (res_n),
    .wr             (wr_bus),
    .out            (out),
    .active         (active),
    .commit_pending (commit_pending),
    .period_tick    (period_tick)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    ph = (ph + 1) % 16;
  endtask

  task automatic wr(input logic [6:0] a, input logic [7:0] d);
    wr_bus.wr_en   = 1'b1;
    wr_bus.wr_addr = a;
    wr_bus.wr_data = d;
    step();
    wr_bus.wr_en   = 1'b0;
  endtask

  task automatic wait_tick();
    int k;
    k = 0;
    do begin
      step();
      k++;
    end while (period_tick !== 1'b1 && k < 40);
    chk("tick_wait", period_tick, 1);
    ph = 15;
  endtask

  function automatic logic [N_CH-1:0] exp_out(input int c, input int duty, input int p0, input int p5);
    logic [N_CH-1:0] v;
    int p;
    for (int i = 0; i < N_CH; i++) begin
      p = (i == 0) ? p0 : ((i == 5) ? p5 : 0);
      v[i] = ((((c - p) % 16) + 16) % 16) < duty;
    end
    return v;
  endfunction

  task automatic check_period(input string tag, input int duty, input int p0, input int p5);
    for (int k = 0; k < 16; k++) begin
      chk(tag, out, exp_out(ph - 1, duty, p0, p5));
      chk({tag, "_tick"}, period_tick, (ph == 15));
      step();
    end
  endtask

  task automatic count_burst(input string tag, input int exp_act, input int exp_tk);
    int act;
    int tk;
    int seen;
    act = 0;
    tk = 0;
    seen = 0;
    for (int k = 0; k < 200 && active === 1'b1; k++) begin
      act++;
      if (period_tick === 1'b1) tk++;
      step();
    end
    chk({tag, "_active_cycles"}, act, exp_act);
    chk({tag, "_ticks"}, tk, exp_tk);
    for (int k = 0; k < 20; k++) begin
      if (active !== 1'b0) seen++;
      step();
    end
    chk({tag, "_stays_idle"}, seen, 0);
    chk({tag, "_out_idle"}, out, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    wr_bus.wr_en   = 1'b0;
    wr_bus.wr_addr = '0;
    wr_bus.wr_data = '0;
    repeat (3) @(negedge clk);
    chk("rst_out", out, 0);
    chk("rst_active", active, 0);
    chk("rst_pending", commit_pending, 0);
    chk("rst_tick", period_tick, 0);
    res_n = 1'b1;
    @(negedge clk);

    // 50% square on every channel, first high two cycles after the enable write
    wr(REG_DUTY, 8'd8);
    wr(REG_ENABLE, 8'd1);
    ph = 0;
    chk("t1_active", active, 1);
    chk("t1_out_first", out, 0);
    step();
    check_period("t1_sq_a", 8, 0, 0);
    check_period("t1_sq_b", 8, 0, 0);

    // Phase offset on channel 5
    wait_tick();
    step();
    wr(7'h15, 8'd3);
    wr(REG_DUTY, 8'd4);
    wr(REG_CTRL, 8'h01);
    chk("t2_pending", commit_pending, 1);
    wait_tick();
    step();
    step();
    check_period("t2_phase", 4, 0, 3);

    // Shadow writes without commit do not reach the outputs
    wait_tick();
    step();
    wr(7'h10, 8'd7);
    wr(REG_DUTY, 8'd2);
    chk("t3_no_pending", commit_pending, 0);
    check_period("t3_hold", 4, 0, 3);
    wr(REG_CTRL, 8'h01);
    while (ph != 15) begin
      chk("t3_pending_hi", commit_pending, 1);
      chk("t3_out_old", out, exp_out(ph - 1, 4, 0, 3));
      step();
    end
    chk("t3_pending_wrap", commit_pending, 1);
    chk("t3_tick_wrap", period_tick, 1);
    step();
    chk("t3_pending_lo", commit_pending, 0);
    chk("t3_out_last_old", out, exp_out(15, 4, 0, 3));
    step();
    check_period("t3_new", 2, 7, 3);

    // Commit issued on the wrap cycle applies one period later
    wr(REG_DUTY, 8'd6);
    wait_tick();
    wr(REG_CTRL, 8'h01);
    chk("t4_pending", commit_pending, 1);
    chk("t4_out_old0", out, exp_out(15, 2, 7, 3));
    step();
    check_period("t4_old", 2, 7, 3);
    check_period("t4_new", 6, 7, 3);

    // Duty saturation and duty zero
    wr(REG_DUTY, 8'hFF);
    wr(REG_CTRL, 8'h01);
    wait_tick();
    step();
    step();
    check_period("t5_sat", 15, 7, 3);
    wr(REG_DUTY, 8'd0);
    wr(REG_CTRL, 8'h01);
    wait_tick();
    step();
    step();
    check_period("t5_zero", 0, 7, 3);

    // Disable mid-period: immediate stop, pending commit kept
    wr(REG_DUTY, 8'd8);
    wr(REG_CTRL, 8'h01);
    wait_tick();
    step();
    step();
    step();
    step();
    step();
    chk("t6_out_run", out, exp_out(3, 8, 7, 3));
    wr(REG_CTRL, 8'h01);
    wr(REG_ENABLE, 8'd0);
    chk("t6_active", active, 0);
    chk("t6_out", out, 0);
    chk("t6_pending_kept", commit_pending, 1);
    step();
    chk("t6_out_next", out, 0);

    // Counted bursts
    wr(REG_BURST, 8'd3);
    wr(REG_CTRL, 8'h02);
    wr(REG_ENABLE, 8'd1);
    chk("t7_pending_clr", commit_pending, 0);
    count_burst("t7_b3", 48, 3);
    wr(REG_BURST, 8'd0);
    wr(REG_ENABLE, 8'd1);
    count_burst("t7_b0", 16, 1);

    // Unmapped addresses leave channels and globals untouched
    wr(REG_CTRL, 8'h00);
    wr(REG_DUTY, 8'd8);
    wr(7'h10, 8'd0);
    wr(7'h15, 8'd0);
    wr(7'h35, 8'd5);
    wr(7'h36, 8'd9);
    wr(7'h7F, 8'hFF);
    wr(7'h00, 8'h00);
    wr(7'h05, 8'h03);
    wr(REG_ENABLE, 8'd1);
    ph = 0;
    chk("t8_active", active, 1);
    step();
    check_period("t8_unmapped", 8, 0, 0);
    wr(REG_ENABLE, 8'd0);

    // Asynchronous reset during a burst
    wr(REG_BURST, 8'd3);
    wr(REG_CTRL, 8'h02);
    wr(REG_ENABLE, 8'd1);
    ph = 0;
    step();
    step();
    step();
    step();
    chk("t9_out_run", out, exp_out(3, 8, 0, 0));
    chk("t9_active_run", active, 1);
    #2;
    res_n = 1'b0;
    #1;
    chk("t9_out_rst", out, 0);
    chk("t9_active_rst", active, 0);
    chk("t9_tick_rst", period_tick, 0);
    @(negedge clk);
    res_n = 1'b1;
    step();
    step();
    step();
    chk("t9_idle_after", active, 0);
    chk("t9_out_after", out, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
